// File: rtl/an_sec_seq_decoder.sv
// Sequential single-error-correcting AN-code decoder: bit-serial division, then iterative syndrome search.
// Optional AN_SEC_EARLY_EXIT_EN trades constant latency for early completion.
module an_sec_seq_decoder #(
    parameter  int A    = 18613,
    parameter  int N_W  = 30,
    parameter  int R_W  = 15,
    localparam int CW_W = N_W + R_W,
    localparam int P_W  = $clog2(CW_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] in_w,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_W-1:0]  out_n,
    output logic            out_corr,
    output logic            out_uncorr,
    output logic [P_W-1:0]  out_pos,
    output logic            out_sign
);

    // state | meaning
    // IDLE  | waiting for a codeword, in_ready high
    // DIV   | restoring division, one codeword bit per cycle, MSB first
    // SRCH  | one prep cycle, then compare R against +/-2^i mod A for i = 0..CW_W-1
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {IDLE, DIV, SRCH, DONE} state_t;

    localparam logic [R_W:0]   A_V  = (R_W+1)'(A);
    localparam logic [P_W-1:0] LAST = P_W'(CW_W - 1);

    state_t            state_q, state_d;
    logic [CW_W-1:0]   w_q, w_d, q_q, q_d;
    logic [R_W:0]      r_q, r_d, rneg_q, rneg_d, p_q, p_d;
    logic [N_W:0]      k_q, k_d;
    logic [P_W-1:0]    cnt_q, cnt_d;
    logic              prep_q, prep_d, found_q, found_d;
    logic [N_W-1:0]    f_n_q, f_n_d;
    logic              f_corr_q, f_corr_d, f_uncorr_q, f_uncorr_d, f_sign_q, f_sign_d;
    logic [P_W-1:0]    f_pos_q, f_pos_d;
    logic              out_valid_q, out_valid_d;
    logic [N_W-1:0]    out_n_q, out_n_d;
    logic              out_corr_q, out_corr_d, out_uncorr_q, out_uncorr_d;
    logic [P_W-1:0]    out_pos_q, out_pos_d;
    logic              out_sign_q, out_sign_d;

    logic [R_W:0]      r_shift, t2;
    logic              div_ge, t_ge;
    logic [N_W+1:0]    q_ext, k_ext, n_pos, n_neg, hit_n;
    logic              q_hi, hit_pos, hit_neg, hit_any, hit_ovf;
    logic [N_W-1:0]    hit_res_n;
    logic [P_W-1:0]    hit_res_pos;

    assign r_shift = {r_q[R_W-1:0], w_q[CW_W-1]};
    assign div_ge  = (r_shift >= A_V);
    assign t2      = {p_q[R_W-1:0], 1'b0};
    assign t_ge    = (t2 >= A_V);

    // Q never exceeds N_W+1 bits for a legal A; the upper bits still feed the range check
    assign q_hi    = |q_q[CW_W-1:N_W+2];
    assign q_ext   = q_q[N_W+1:0];
    assign k_ext   = {1'b0, k_q};
    assign n_pos   = q_ext - k_ext;
    assign n_neg   = q_ext + k_ext + (N_W+2)'(1);

    assign hit_pos     = (r_q == p_q);
    assign hit_neg     = (rneg_q == p_q);
    assign hit_any     = hit_pos | hit_neg;
    assign hit_n       = hit_pos ? n_pos : n_neg;
    assign hit_ovf     = (hit_n[N_W+1:N_W] != 2'b00) | q_hi;
    assign hit_res_n   = hit_ovf ? q_q[N_W-1:0] : hit_n[N_W-1:0];
    assign hit_res_pos = hit_ovf ? '0 : cnt_q;

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        q_d          = q_q;
        r_d          = r_q;
        rneg_d       = rneg_q;
        p_d          = p_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        prep_d       = prep_q;
        found_d      = found_q;
        f_n_d        = f_n_q;
        f_corr_d     = f_corr_q;
        f_uncorr_d   = f_uncorr_q;
        f_pos_d      = f_pos_q;
        f_sign_d     = f_sign_q;
        out_valid_d  = out_valid_q;
        out_n_d      = out_n_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        out_pos_d    = out_pos_q;
        out_sign_d   = out_sign_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = in_w;
                    q_d     = '0;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                r_d   = div_ge ? (r_shift - A_V) : r_shift;
                q_d   = {q_q[CW_W-2:0], div_ge};
                w_d   = {w_q[CW_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    prep_d  = 1'b1;
                    state_d = SRCH;
                end
            end
            SRCH: begin
                if (prep_q) begin
                    // precomputing A-R keeps the negative-error compare off the subtractor path
                    prep_d  = 1'b0;
                    rneg_d  = A_V - r_q;
                    p_d     = (R_W+1)'(1);
                    k_d     = '0;
                    cnt_d   = '0;
                    found_d = 1'b0;
`ifdef AN_SEC_EARLY_EXIT_EN
                    if (r_q == '0) begin
                        out_n_d      = q_q[N_W-1:0];
                        out_corr_d   = 1'b0;
                        out_uncorr_d = 1'b0;
                        out_pos_d    = '0;
                        out_sign_d   = 1'b0;
                        out_valid_d  = 1'b1;
                        state_d      = DONE;
                    end
`endif
                end else begin
                    p_d   = t_ge ? (t2 - A_V) : t2;
                    k_d   = {k_q[N_W-1:0], t_ge};
                    cnt_d = cnt_q + 1'b1;
`ifdef AN_SEC_EARLY_EXIT_EN
                    if (hit_any) begin
                        out_n_d      = hit_res_n;
                        out_corr_d   = ~hit_ovf;
                        out_uncorr_d = hit_ovf;
                        out_pos_d    = hit_res_pos;
                        out_sign_d   = hit_neg & ~hit_ovf;
                        out_valid_d  = 1'b1;
                        state_d      = DONE;
                    end else if (cnt_q == LAST) begin
                        out_n_d      = q_q[N_W-1:0];
                        out_corr_d   = 1'b0;
                        out_uncorr_d = 1'b1;
                        out_pos_d    = '0;
                        out_sign_d   = 1'b0;
                        out_valid_d  = 1'b1;
                        state_d      = DONE;
                    end
`else
                    if (hit_any && !found_q) begin
                        found_d    = 1'b1;
                        f_n_d      = hit_res_n;
                        f_corr_d   = ~hit_ovf;
                        f_uncorr_d = hit_ovf;
                        f_pos_d    = hit_res_pos;
                        f_sign_d   = hit_neg & ~hit_ovf;
                    end
                    if (cnt_q == LAST) begin
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                        if (found_q) begin
                            out_n_d      = f_n_q;
                            out_corr_d   = f_corr_q;
                            out_uncorr_d = f_uncorr_q;
                            out_pos_d    = f_pos_q;
                            out_sign_d   = f_sign_q;
                        end else if (hit_any) begin
                            out_n_d      = hit_res_n;
                            out_corr_d   = ~hit_ovf;
                            out_uncorr_d = hit_ovf;
                            out_pos_d    = hit_res_pos;
                            out_sign_d   = hit_neg & ~hit_ovf;
                        end else begin
                            out_n_d      = q_q[N_W-1:0];
                            out_corr_d   = 1'b0;
                            out_uncorr_d = (r_q != '0);
                            out_pos_d    = '0;
                            out_sign_d   = 1'b0;
                        end
                    end
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            w_q          <= '0;
            q_q          <= '0;
            r_q          <= '0;
            rneg_q       <= '0;
            p_q          <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            prep_q       <= 1'b0;
            found_q      <= 1'b0;
            f_n_q        <= '0;
            f_corr_q     <= 1'b0;
            f_uncorr_q   <= 1'b0;
            f_pos_q      <= '0;
            f_sign_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_n_q      <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_pos_q    <= '0;
            out_sign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_q          <= w_d;
            q_q          <= q_d;
            r_q          <= r_d;
            rneg_q       <= rneg_d;
            p_q          <= p_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            prep_q       <= prep_d;
            found_q      <= found_d;
            f_n_q        <= f_n_d;
            f_corr_q     <= f_corr_d;
            f_uncorr_q   <= f_uncorr_d;
            f_pos_q      <= f_pos_d;
            f_sign_q     <= f_sign_d;
            out_valid_q  <= out_valid_d;
            out_n_q      <= out_n_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            out_pos_q    <= out_pos_d;
            out_sign_q   <= out_sign_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_n      = out_n_q;
    assign out_corr   = out_corr_q;
    assign out_uncorr = out_uncorr_q;
    assign out_pos    = out_pos_q;
    assign out_sign   = out_sign_q;

endmodule

// File: doc/an_sec_seq_decoder.md
# an_sec_seq_decoder

Sequential, parametrised single-error-correcting AN-code decoder. It accepts a received codeword W = A·N + e, where e is zero or a single arithmetic-weight error ±2^i. It returns the corrected N together with error position, sign and status flags. Remainder computation and syndrome search are iterative, so no per-A lookup table is needed, and any odd A meeting the range rule below is supported. It sits between the AN-coded datapath or storage and the consumers of decoded operands, with valid/ready flow control on both sides.

## Interface
- `A`, default 18613: code multiplier. Must be odd, with 2^(R_W-1) < A < 2^R_W. All ±2^i mod A values for i in [0, CW_W-1] must be distinct and nonzero.
- `N_W`, default 30: data width.
- `R_W`, default 15: remainder width.
- `CW_W`, fixed at N_W+R_W: codeword width (derived localparam, not user-set).
- `P_W`, fixed at $clog2(CW_W): width of the error-position field (derived localparam).
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: codeword offered.
- `in_ready`, out, 1: decoder can accept a codeword.
- `in_w`, in, CW_W: received codeword W.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer accepts the result.
- `out_n`, out, N_W: corrected data.
- `out_corr`, out, 1: a single error was found and corrected.
- `out_uncorr`, out, 1: error detected but not correctable.
- `out_pos`, out, P_W: error bit index i (0 when there is no correction).
- `out_sign`, out, 1: error sign; 0 means e = +2^i, 1 means e = −2^i.

## Operation
- FSM states: IDLE, DIV, SRCH, DONE. Reset enters IDLE.
- Reset values: in_ready=1; out_valid, out_n, out_corr, out_uncorr, out_pos, out_sign all 0.
- **IDLE**
  - in_ready=1.
  - On in_valid, latch W, clear Q and R, set counter=0, then go to DIV.
- **DIV**
  - Restoring division, one bit per cycle, MSB first, for CW_W cycles.
  - Each cycle: R' = 2R + w[bit]; if R' ≥ A, subtract A and shift 1 into Q, else shift 0. The R datapath is R_W+1 bits wide.
  - At the end: R = W mod A, Q = W div A (CW_W bits).
- **SRCH**
  - Iterator p_0 = 1, k_0 = 0.
  - Step: t = 2p_i; p_{i+1} = t − A if t ≥ A, else t; k_{i+1} = 2k_i + (t ≥ A). This gives p_i = 2^i mod A and k_i = 2^i div A; k is N_W+1 bits.
  - Each cycle compares R against both candidates:
    - R == p_i: positive error. N = Q − k_i, pos=i, sign=0.
    - R == A − p_i: negative error. N = Q + k_i + 1, pos=i, sign=1.
  - Index i runs from 0 to CW_W−1.
- **Result rules**
  - R == 0: N = Q, corr=0, uncorr=0.
  - A candidate matched: corr=1. If the computed N ≥ 2^N_W or is negative (checked at N_W+2-bit width), set uncorr=1 and corr=0 instead.
  - No match after all CW_W indices: uncorr=1, out_n = Q[N_W-1:0].
- **DONE**
  - out_valid=1, in_ready=0.
  - Outputs are held stable until out_valid & out_ready, then return to IDLE.
  - No new codeword is accepted in the same cycle (single item in flight).
- **Reset mid-operation:** any state returns to IDLE on the next edge. The in-flight codeword is discarded and no out_valid pulse appears.

## Timing
- Accept edge = edge 0.
- DIV spans edges 1..CW_W.
- With early exit:
  - R==0: out_valid after edge CW_W+1.
  - Match at index i: out_valid after edge CW_W+2+i.
  - No match: out_valid after edge 2·CW_W+1.
- in_ready is 0 from edge 1 until the edge after the output handshake.
- Throughput: at most one codeword per (latency + 1) cycles.
- out_* are registered and change only on entry to DONE or on reset.

## Configuration
- Macro `AN_SEC_EARLY_EXIT_EN`.
- **Defined:**
  - R==0 skips SRCH entirely.
  - SRCH ends at the first matching index.
  - Latency is variable, per the Timing section.
- **Undefined:**
  - SRCH always runs all CW_W indices, even when R==0.
  - The first match is captured and later indices are ignored.
  - Latency is constant at 2·CW_W+1 cycles (91 at defaults), for timing-invariant decode.

## Test plan
Defaults: A=18613, CW_W=45. Base word W0 = 12345·18613 = 229777485.
- **Clean codeword.** W0 → out_n=12345, corr=0, uncorr=0. Latency 46 with early exit, 91 without.
- **Error +2^0.** W0+1 (R=1) → out_n=12345, corr=1, pos=0, sign=0. Latency 47 with early exit.
- **Error −2^15.** W0−32768 (R=4458) → out_n=12345, corr=1, pos=15, sign=1. Latency 62 with early exit.
- **Uncorrectable.** W0+3 (R=3, not a syndrome) → uncorr=1, corr=0, out_n=12345. Latency 91 in both builds.
- **Backpressure.** Hold out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0, in_valid ignored. Result consumed on the first cycle out_ready=1; in_ready=1 on the next cycle.
- **Reset mid-operation.** Assert rst during DIV cycle 20 → next cycle in_ready=1 and out_valid=0. A fresh W0 then decodes correctly.
